phy_utx_gen: RTL and testbench

Parametrised UART transmitter for the commu_top PHY layer. It runs its own baud divider rather than depending on an external microsecond pulse. It buffers outgoing words in a small FIFO behind a valid/ready handshake. Frame format is runtime-selectable (parity mode, one or two stop bits) and the data width is set by parameter. It sits between the framing/protocol logic and the board `uart_tx` pin.

---
 rtl/phy_utx_gen.sv | 199 +++++++++++++++++++
 tb/tb_phy_utx_gen.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_utx_gen.sv
// phy_utx_gen
// UART transmitter for the PHY layer. Outgoing words are buffered in a small
// FIFO behind a valid/ready handshake. A private baud divider sets the bit rate,
// and the frame format (parity mode, stop-bit count) is chosen at run time.
//
// Ports
//   clk_sys      system clock, rising edge
//   rst          synchronous active-high reset
//   tx_data      word to send, LSB first
//   tx_vld       tx_data valid; a push happens when tx_vld & tx_rdy
//   tx_rdy       FIFO has room (low while rst is high)
//   baud_div     bit period = baud_div+1 clocks (0 behaves like 1)
//   parity_mode  00 none, 01 even, 10 odd, 11 mark
//   stop2        1 = two stop bits, 0 = one
//   uart_tx      serial line, idle high, driven from a single flop
//   tx_busy      FSM not idle
//   fifo_cnt     words currently buffered
//
// state  | meaning
// IDLE   | line high, waiting for a buffered word
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | parity bit (even / odd / mark)
// STOP   | one or two stop bits (1); may pop the next word with no idle gap
module phy_utx_gen #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                        clk_sys,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_vld,
  output logic                        tx_rdy,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop2,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  state_t            state;
  logic [DIV_W-1:0]  timer;
  logic [DIV_W-1:0]  div_l;
  logic [DIV_W-1:0]  div_eff;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0]     bit_idx;
  logic              par_en_l;
  logic              par_l;
  logic              stop2_l;
  logic              stop_idx;
  logic              par_calc;
  logic              bit_end;
  logic              last_stop;
  logic              line_nxt;

  assign tx_rdy    = !rst && (fifo_cnt < CW'(FIFO_DEPTH));
  assign push      = tx_vld && tx_rdy;
  assign head      = mem[rd_ptr];
  assign bit_end   = (timer == '0);
  assign last_stop = stop_idx || !stop2_l;
  // A pop only happens from IDLE or at the very end of the last stop bit.
  assign pop       = (fifo_cnt != '0) &&
                     ((state == S_IDLE) || ((state == S_STOP) && bit_end && last_stop));
  // A divisor of 0 would give a 1-clock bit; clamp it so 0 and 1 both give 2.
  assign div_eff   = (baud_div == '0) ? DIV_W'(1) : baud_div;

  always_comb begin
    case (parity_mode)
      2'b01:   par_calc = ^head;
      2'b10:   par_calc = ~^head;
      2'b11:   par_calc = 1'b1;
      default: par_calc = 1'b0;
    endcase
  end

  // Line value for the bit currently in progress. It is registered into
  // uart_tx, so the line trails the state by one clock.
  always_comb begin
    case (state)
      S_START:  line_nxt = 1'b0;
      S_DATA:   line_nxt = sh[0];
      S_PARITY: line_nxt = par_l;
      default:  line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= S_IDLE;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      timer    <= '0;
      div_l    <= '0;
      sh       <= '0;
      bit_idx  <= '0;
      par_en_l <= 1'b0;
      par_l    <= 1'b0;
      stop2_l  <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      uart_tx <= line_nxt;
      case (state)
        S_START: begin
          if (bit_end) begin
            timer   <= div_l;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            timer <= timer - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer <= div_l;
            sh    <= sh >> 1;
            if (bit_idx == BW'(DATA_W - 1)) begin
              stop_idx <= 1'b0;
              state    <= par_en_l ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer - DIV_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            timer    <= div_l;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end else begin
            timer <= timer - DIV_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            timer <= div_l;
            if (last_stop) begin
              state   <= S_IDLE;
              tx_busy <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            timer <= timer - DIV_W'(1);
          end
        end
        default: ;
      endcase
      // Latching a new word overrides the IDLE/STOP transitions above, which
      // gives back-to-back frames with no idle cycle on the line.
      if (pop) begin
        sh       <= head;
        div_l    <= div_eff;
        timer    <= div_eff;
        par_en_l <= |parity_mode;
        par_l    <= par_calc;
        stop2_l  <= stop2;
        state    <= S_START;
        tx_busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phy_utx_gen.sv
module tb_phy_utx_gen;
  logic        clk_sys = 1'b0;
  logic        rst;

  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        uart_tx;
  logic        tx_busy;
  logic [2:0]  fifo_cnt;

  logic [4:0]  tx_data5;
  logic        tx_vld5;
  logic        tx_rdy5;
  logic [15:0] baud_div5;
  logic [1:0]  parity_mode5;
  logic        stop2_5;
  logic        uart_tx5;
  logic        tx_busy5;
  logic [2:0]  fifo_cnt5;

  int checks = 0;
  int errors = 0;

  logic       cap_tx    [0:255];
  logic       cap_busy  [0:255];
  logic       cap_tx5   [0:255];
  logic       cap_busy5 [0:255];
  logic [2:0] cap_cnt   [0:255];
  logic       cap_rdy   [0:255];

  always #5 clk_sys = ~clk_sys;

  phy_utx_gen #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) u_dut8 (
    .clk_sys(clk_sys), .rst(rst), .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .baud_div(baud_div), .parity_mode(parity_mode), .stop2(stop2),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_cnt(fifo_cnt));

  phy_utx_gen #(.DATA_W(5), .FIFO_DEPTH(4), .DIV_W(16)) u_dut5 (
    .clk_sys(clk_sys), .rst(rst), .tx_data(tx_data5), .tx_vld(tx_vld5), .tx_rdy(tx_rdy5),
    .baud_div(baud_div5), .parity_mode(parity_mode5), .stop2(stop2_5),
    .uart_tx(uart_tx5), .tx_busy(tx_busy5), .fifo_cnt(fifo_cnt5));

  // Record n consecutive negedge samples of both instances.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      cap_tx[i]    = uart_tx;
      cap_busy[i]  = tx_busy;
      cap_tx5[i]   = uart_tx5;
      cap_busy5[i] = tx_busy5;
      cap_cnt[i]   = fifo_cnt;
      cap_rdy[i]   = tx_rdy;
    end
  endtask

  // Value held over a window of captured samples, or x if it moved.
  function automatic logic win(input int sel, input int base, input int n);
    logic v, s;
    v = 1'bx;
    for (int j = 0; j < n; j++) begin
      case (sel)
        0:       s = cap_tx[base+j];
        1:       s = cap_busy[base+j];
        2:       s = cap_tx5[base+j];
        default: s = cap_busy5[base+j];
      endcase
      if (j == 0) v = s;
      else if (s !== v) v = 1'bx;
    end
    return v;
  endfunction

  task automatic test_reset();
    @(negedge clk_sys);
    checks++;
    if ({uart_tx, tx_busy, fifo_cnt, tx_rdy} !== 6'b1_0_000_0) begin
      errors++;
      $display("FAIL reset_state got tx=%b busy=%b cnt=%0d rdy=%b want tx=1 busy=0 cnt=0 rdy=0",
               uart_tx, tx_busy, fifo_cnt, tx_rdy);
    end
    checks++;
    if ({uart_tx5, tx_busy5, tx_rdy5} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state5 got tx=%b busy=%b rdy=%b want 1 0 0", uart_tx5, tx_busy5, tx_rdy5);
    end
    @(posedge clk_sys); #1 rst = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({tx_rdy, tx_rdy5} !== 2'b11) begin
      errors++;
      $display("FAIL rdy_after_reset got %b%b want 11", tx_rdy, tx_rdy5);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_single_frame();
    logic [9:0] e;
    logic v;
    e = 10'b1010101010;
    baud_div = 16'd9; parity_mode = 2'b00; stop2 = 1'b0;
    tx_data = 8'h55; tx_vld = 1'b1;
    @(posedge clk_sys); #1 tx_vld = 1'b0;
    capture(110);
    checks++;
    if (cap_cnt[0] !== 3'd1) begin
      errors++; $display("FAIL single_cnt got %0d want 1", cap_cnt[0]);
    end
    checks++;
    if ({cap_tx[1], cap_tx[2]} !== 2'b10) begin
      errors++; $display("FAIL single_start_latency got %b%b want 10", cap_tx[1], cap_tx[2]);
    end
    for (int k = 0; k < 10; k++) begin
      v = win(0, 2 + 10*k, 10);
      checks++;
      if (v !== e[k]) begin
        errors++; $display("FAIL single_bit%0d got %b want %b", k, v, e[k]);
      end
    end
    v = win(0, 102, 8);
    checks++;
    if (v !== 1'b1) begin
      errors++; $display("FAIL single_idle_after got %b want 1", v);
    end
    v = win(1, 1, 100);
    checks++;
    if ({cap_busy[0], v, cap_busy[101]} !== 3'b010) begin
      errors++;
      $display("FAIL single_busy got pre=%b during=%b post=%b want 0 1 0", cap_busy[0], v, cap_busy[101]);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_parity();
    logic [11:0] e;
    logic v;
    int n;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0:       begin parity_mode = 2'b01; stop2 = 1'b1; n = 12; e = 12'b1111_0100_1110; end
        1:       begin parity_mode = 2'b10; stop2 = 1'b0; n = 11; e = 12'b0101_0100_1110; end
        default: begin parity_mode = 2'b11; stop2 = 1'b0; n = 11; e = 12'b0111_0100_1110; end
      endcase
      baud_div = 16'd9;
      tx_data = 8'hA7; tx_vld = 1'b1;
      @(posedge clk_sys); #1 tx_vld = 1'b0;
      capture(n*10 + 10);
      for (int k = 0; k < n; k++) begin
        v = win(0, 2 + 10*k, 10);
        checks++;
        if (v !== e[k]) begin
          errors++; $display("FAIL parity_cfg%0d_bit%0d got %b want %b", c, k, v, e[k]);
        end
      end
      v = win(1, 1, n*10);
      checks++;
      if ({v, cap_busy[n*10+1]} !== 2'b10) begin
        errors++;
        $display("FAIL parity_cfg%0d_len got during=%b after=%b want 1 0", c, v, cap_busy[n*10+1]);
      end
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic test_back_to_back();
    int acc_edge [7];
    int want_edge [7];
    int d;
    int c;
    logic r;
    logic v;
    logic [9:0] e;
    logic [7:0] w;
    want_edge = '{0, 0, 1, 2, 3, 4, 22};
    for (int i = 0; i < 7; i++) acc_edge[i] = -1;
    baud_div = 16'd1; parity_mode = 2'b00; stop2 = 1'b0;
    d = 1; c = 0;
    tx_data = 8'h01; tx_vld = 1'b1;
    fork
      capture(130);
      begin
        while (d <= 6 && c < 100) begin
          @(negedge clk_sys) r = tx_rdy;
          @(posedge clk_sys);
          if (r) begin acc_edge[d] = c; d++; end
          c++;
          #1;
          if (d <= 6) tx_data = 8'(d);
          else tx_vld = 1'b0;
        end
        tx_vld = 1'b0;
      end
    join
    checks++;
    if (d != 7) begin
      errors++; $display("FAIL b2b_accept_timeout got %0d words want 6", d - 1);
    end
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if (acc_edge[i] != want_edge[i]) begin
        errors++; $display("FAIL b2b_accept_edge%0d got %0d want %0d", i, acc_edge[i], want_edge[i]);
      end
    end
    checks++;
    if ({cap_cnt[5], cap_rdy[5]} !== 4'b100_0) begin
      errors++; $display("FAIL b2b_full got cnt=%0d rdy=%b want cnt=4 rdy=0", cap_cnt[5], cap_rdy[5]);
    end
    for (int f = 0; f < 6; f++) begin
      w = 8'(f + 1);
      e = {1'b1, w, 1'b0};
      for (int k = 0; k < 10; k++) begin
        v = win(0, 3 + 20*f + 2*k, 2);
        checks++;
        if (v !== e[k]) begin
          errors++; $display("FAIL b2b_frame%0d_bit%0d got %b want %b", f, k, v, e[k]);
        end
      end
    end
    v = win(1, 2, 120);
    checks++;
    if ({v, cap_busy[122], cap_tx[123]} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_busy_gapless got during=%b after=%b line=%b want 1 0 1", v, cap_busy[122], cap_tx[123]);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_cfg_change();
    logic [9:0] e;
    logic v;
    baud_div = 16'd9; parity_mode = 2'b00; stop2 = 1'b0;
    tx_data = 8'h0F; tx_vld = 1'b1;
    @(posedge clk_sys); #1 tx_data = 8'h3C;
    @(posedge clk_sys); #1 tx_vld = 1'b0;
    fork
      capture(160);
      begin
        repeat (40) @(posedge clk_sys);
        #1 baud_div = 16'd4;
      end
    join
    e = {1'b1, 8'h0F, 1'b0};
    for (int k = 0; k < 10; k++) begin
      v = win(0, 1 + 10*k, 10);
      checks++;
      if (v !== e[k]) begin
        errors++; $display("FAIL cfg_frame1_bit%0d got %b want %b", k, v, e[k]);
      end
    end
    e = {1'b1, 8'h3C, 1'b0};
    for (int k = 0; k < 10; k++) begin
      v = win(0, 101 + 5*k, 5);
      checks++;
      if (v !== e[k]) begin
        errors++; $display("FAIL cfg_frame2_bit%0d got %b want %b", k, v, e[k]);
      end
    end
    v = win(1, 0, 150);
    checks++;
    if ({v, cap_busy[150], win(0, 151, 8)} !== 3'b101) begin
      errors++;
      $display("FAIL cfg_len got during=%b after=%b idle=%b want 1 0 1", v, cap_busy[150], win(0, 151, 8));
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_reset_mid();
    logic v;
    baud_div = 16'd9; parity_mode = 2'b00; stop2 = 1'b0;
    tx_data = 8'h00; tx_vld = 1'b1;
    @(posedge clk_sys); #1 tx_data = 8'h11;
    @(posedge clk_sys); #1 tx_data = 8'h22;
    @(posedge clk_sys); #1 tx_data = 8'h33;
    @(posedge clk_sys); #1 tx_vld = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({fifo_cnt, tx_busy} !== 4'b011_1) begin
      errors++; $display("FAIL rstmid_queued got cnt=%0d busy=%b want 3 1", fifo_cnt, tx_busy);
    end
    repeat (41) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++; $display("FAIL rstmid_in_bit3 got %b want 0", uart_tx);
    end
    @(posedge clk_sys); #1 rst = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if ({uart_tx, fifo_cnt, tx_busy, tx_rdy} !== 6'b1_000_0_0) begin
      errors++;
      $display("FAIL rstmid_state got tx=%b cnt=%0d busy=%b rdy=%b want 1 0 0 0", uart_tx, fifo_cnt, tx_busy, tx_rdy);
    end
    #1 rst = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (tx_rdy !== 1'b1) begin
      errors++; $display("FAIL rstmid_rdy got %b want 1", tx_rdy);
    end
    capture(200);
    v = win(0, 0, 200);
    checks++;
    if ({v, win(1, 0, 200), cap_cnt[199]} !== 5'b1_0_000) begin
      errors++;
      $display("FAIL rstmid_no_frames got line=%b busy=%b cnt=%0d want 1 0 0", v, win(1, 0, 200), cap_cnt[199]);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_narrow();
    logic [6:0] e;
    logic v;
    e = 7'b1100110;
    for (int dv = 0; dv < 2; dv++) begin
      baud_div5 = 16'(dv);
      tx_data5 = 5'h13; tx_vld5 = 1'b1;
      @(posedge clk_sys); #1 tx_vld5 = 1'b0;
      capture(20);
      for (int k = 0; k < 7; k++) begin
        v = win(2, 2 + 2*k, 2);
        checks++;
        if (v !== e[k]) begin
          errors++; $display("FAIL narrow_div%0d_bit%0d got %b want %b", dv, k, v, e[k]);
        end
      end
      v = win(3, 1, 14);
      checks++;
      if ({v, cap_busy5[15], win(2, 16, 4)} !== 3'b101) begin
        errors++;
        $display("FAIL narrow_div%0d_len got during=%b after=%b idle=%b want 1 0 1", dv, v, cap_busy5[15], win(2, 16, 4));
      end
      @(posedge clk_sys); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tx_data = '0; tx_vld = 1'b0; baud_div = 16'd9; parity_mode = 2'b00; stop2 = 1'b0;
    tx_data5 = '0; tx_vld5 = 1'b0; baud_div5 = 16'd0; parity_mode5 = 2'b00; stop2_5 = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    test_narrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
